// File: rtl/proj1.sv
// proj1 -- registered signed ALU.
//
// Purpose:
//   Single-cycle WIDTH-bit two's-complement ALU with registered outputs.
//   Supported operations are add, subtract, bidirectional shift and four
//   bitwise logic ops. The result and the N/Z/C/V flags are computed
//   combinationally from the operands. Both are loaded together on the next
//   rising edge of i_clk. A new operation is accepted every cycle.
//
// Ports:
//   i_clk     in   1      rising-edge clock
//   i_rst_n   in   1      asynchronous active-low reset; clears outputs at once
//   i_arg0    in   WIDTH  operand A (signed)
//   i_arg1    in   WIDTH  operand B (signed); signed shift amount for SHIFT
//   i_oper    in   3      opcode: 0 ADD, 1 SUB, 2 SHIFT, 3 AND, 4 OR,
//                         5 XOR, 6 XNOR, 7 reserved (result 0, flags 0)
//   o_result  out  WIDTH  registered result
//   o_flag    out  4      registered flags {N, Z, C, V}
//
// WIDTH must be at least 2.
module proj1 #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [2:0]       i_oper,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag
);

  localparam int MSB = WIDTH - 1;
  // Shift counts below WIDTH fit in this many bits.
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] SH_LIM = (WIDTH+1)'(WIDTH);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_SHIFT = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_RSV   = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flag;
  } alu_rsp_t;

  op_e              op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH:0]   sh_mag;
  logic             sh_big;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic             c_flag;
  logic             v_flag;
  alu_rsp_t         rsp_d;
  alu_rsp_t         rsp_q;

  assign op = op_e'(i_oper);

  // Arithmetic and shifter datapath
  always_comb begin
    // One extra bit gives the unsigned carry (ADD) and the borrow (SUB).
    sum_ext = {1'b0, i_arg0} + {1'b0, i_arg1};
    dif_ext = {1'b0, i_arg0} - {1'b0, i_arg1};

    // Shift distance is |B|. It is computed one bit wider so that
    // -(-2^(WIDTH-1)) cannot overflow.
    sh_mag = i_arg1[MSB] ? (~{i_arg1[MSB], i_arg1} + ONE_X) : {1'b0, i_arg1};
    sh_big = (sh_mag >= SH_LIM);
    sh_amt = sh_mag[SHW-1:0];

    // Distances of WIDTH or more saturate to all-zero (left shift) or
    // all-sign (right shift). Only in-range distances use the barrel shifter.
    shl = sh_big ? '0 : (i_arg0 << sh_amt);
    shr = sh_big ? {WIDTH{i_arg0[MSB]}} : WIDTH'($signed(i_arg0) >>> sh_amt);
  end

  // Result select and flag generation
  always_comb begin
    rsp_d.res = '0;
    c_flag    = 1'b0;
    v_flag    = 1'b0;
    unique case (op)
      OP_ADD: begin
        rsp_d.res = sum_ext[MSB:0];
        c_flag    = sum_ext[WIDTH];
        v_flag    = (i_arg0[MSB] == i_arg1[MSB]) && (rsp_d.res[MSB] != i_arg0[MSB]);
      end
      OP_SUB: begin
        rsp_d.res = dif_ext[MSB:0];
        c_flag    = dif_ext[WIDTH];
        v_flag    = (i_arg0[MSB] != i_arg1[MSB]) && (rsp_d.res[MSB] != i_arg0[MSB]);
      end
      OP_SHIFT: begin
        if (i_arg1 == '0)      rsp_d.res = i_arg0;
        else if (i_arg1[MSB])  rsp_d.res = shr;
        else                   rsp_d.res = shl;
      end
      OP_AND:  rsp_d.res = i_arg0 & i_arg1;
      OP_OR:   rsp_d.res = i_arg0 | i_arg1;
      OP_XOR:  rsp_d.res = i_arg0 ^ i_arg1;
      OP_XNOR: rsp_d.res = ~(i_arg0 ^ i_arg1);
      default: rsp_d.res = '0;
    endcase
    // Opcode 7 reports no flags at all. In particular Z stays clear even
    // though its result is 0.
    rsp_d.flag = (op == OP_RSV) ? 4'b0000
               : {rsp_d.res[MSB], (rsp_d.res == '0), c_flag, v_flag};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rsp_q <= '0;
    else          rsp_q <= rsp_d;
  end

  assign o_result = rsp_q.res;
  assign o_flag   = rsp_q.flag;

endmodule

// File: tb/tb_proj1.sv
// Directed and randomized bench for proj1. The expected result and flags are
// queued when inputs are driven and compared one edge later.
module tb_proj1;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [9:0] i_arg0, i_arg1;
  logic [2:0] i_oper;
  logic [9:0] o_result;
  logic [3:0] o_flag;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct packed { logic [9:0] r; logic [3:0] f; } exp_t;
  exp_t  sb_q[$];
  string tag_q[$];

  proj1 #(.WIDTH(10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_arg0(i_arg0), .i_arg1(i_arg1),
    .i_oper(i_oper), .o_result(o_result), .o_flag(o_flag)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Independent reference using integer arithmetic; returns {result, N,Z,C,V}.
  function automatic logic [13:0] model(input logic [9:0] a, input logic [9:0] b,
                                        input logic [2:0] op);
    int sa, sb, ua, ub, r;
    logic c, v;
    logic [9:0] res;
    sa = $signed(a); sb = $signed(b);
    ua = int'(a);    ub = int'(b);
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      3'd0: begin r = sa + sb; c = (ua + ub) > 1023; v = (r > 511) || (r < -512); end
      3'd1: begin r = sa - sb; c = ua < ub;          v = (r > 511) || (r < -512); end
      3'd2: begin
        if (sb == 0)       r = sa;
        else if (sb > 0)   r = (sb >= 10) ? 0 : (ua << sb);
        else               r = (sb <= -10) ? ((sa < 0) ? -1 : 0) : (sa >>> (-sb));
      end
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: r = ~(ua ^ ub);
      default: return 14'd0;
    endcase
    res = r[9:0];
    return {res, res[9], (res == 10'd0), c, v};
  endfunction

  // Drive one operation, queue its expectation, check it just after the edge.
  task automatic step(input string tag, input logic [9:0] a, input logic [9:0] b,
                      input logic [2:0] op, input logic [9:0] er, input logic [3:0] ef);
    exp_t  e;
    string t;
    @(negedge i_clk);
    i_arg0 = a; i_arg1 = b; i_oper = op;
    sb_q.push_back('{r: er, f: ef});
    tag_q.push_back(tag);
    @(posedge i_clk);
    #1;
    total++;
    assert (sb_q.size() != 0) pass_cnt++;
    else $error("FAIL %s: scoreboard empty got 0 expected 1", tag);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".res"}, o_result, e.r);
      chk({t, ".flag"}, {6'd0, o_flag}, {6'd0, e.f});
    end
  endtask

  task automatic mstep(input string tag, input logic [9:0] a, input logic [9:0] b,
                       input logic [2:0] op);
    logic [13:0] m;
    m = model(a, b, op);
    step(tag, a, b, op, m[13:4], m[3:0]);
  endtask

  initial begin
    // Reset with nonzero inputs: outputs clear without any clock edge.
    i_arg0 = 10'd64; i_arg1 = 10'd16; i_oper = 3'd4; i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst.res", o_result, 10'd0);
    chk("rst.flag", {6'd0, o_flag}, 10'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;

    step("add",   10'd64, 10'd16, 3'd0, 10'd80, 4'b0000);
    step("sub",   10'd64, 10'd16, 3'd1, 10'd48, 4'b0000);
    step("shl4",  10'd64, 10'd4,  3'd2, 10'd0,  4'b0100);
    step("shr4",  10'd64, 10'(-4), 3'd2, 10'd4, 4'b0000);
    step("sh0",   10'd64, 10'd0,  3'd2, 10'd64, 4'b0000);
    step("ashr",  10'(-64), 10'(-4), 3'd2, 10'(-4), 4'b1000);
    step("shl10", 10'd1,  10'd10, 3'd2, 10'd0,  4'b0100);
    step("shl9",  10'd1,  10'd9,  3'd2, 10'h200, 4'b1000);
    step("shr10n", 10'(-5), 10'(-10), 3'd2, 10'h3FF, 4'b1000);
    step("shr512", 10'd100, 10'h200, 3'd2, 10'd0, 4'b0100);
    step("and",   10'd64, 10'd16, 3'd3, 10'd0,  4'b0100);
    step("or",    10'd64, 10'd16, 3'd4, 10'd80, 4'b0000);
    step("xor",   10'd64, 10'd16, 3'd5, 10'd80, 4'b0000);
    step("xnor",  10'd64, 10'd16, 3'd6, 10'(-81), 4'b1000);
    step("rsv",   10'd64, 10'd16, 3'd7, 10'd0,  4'b0000);
    step("addovp", 10'd511, 10'd511, 3'd0, 10'(-2), 4'b1001);
    step("addovn", 10'(-511), 10'(-511), 3'd0, 10'd2, 4'b0011);
    step("subov1", 10'd511, 10'(-511), 3'd1, 10'(-2), 4'b1011);
    step("subov2", 10'(-511), 10'd511, 3'd1, 10'd2, 4'b0001);
    step("sub3",  10'd200, 10'(-100), 3'd1, 10'd300, 4'b0010);
    step("sub4",  10'(-200), 10'd100, 3'd1, 10'(-300), 4'b1000);
    step("sub5",  10'd200, 10'd300, 3'd1, 10'(-100), 4'b1010);
    step("sub6",  10'(-200), 10'(-300), 3'd1, 10'd100, 4'b0000);

    // Back-to-back: the opcode changes every cycle.
    for (int k = 0; k < 8; k++) mstep($sformatf("b2b%0d", k), 10'd300, 10'(-7), 3'(k));

    // Pulse reset between edges. The outputs clear immediately.
    step("pre_rst", 10'd64, 10'd16, 3'd0, 10'd80, 4'b0000);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst.res", o_result, 10'd0);
    chk("midrst.flag", {6'd0, o_flag}, 10'd0);
    #1 i_rst_n = 1'b1;
    step("post_rst", 10'd100, 10'd27, 3'd1, 10'd73, 4'b0000);

    // Randomized operands checked against the integer model.
    for (int k = 0; k < 60; k++)
      mstep($sformatf("rnd%0d", k), 10'($urandom),
            (k % 2 == 0) ? 10'($urandom_range(0, 1023)) : 10'($signed(5'($urandom))),
            3'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
